// File: rtl/gnn_load_pkg.sv
// gnn_load_pkg
// Shared definitions for the load-instruction dispatch slice:
//   - bit positions of the fields inside a 128-bit load instruction
//   - the five buffer-group codes a load instruction may target
//   - the dispatcher state encoding
//   - is_legal_load_inst(): screens instructions that would hang the load stage
package gnn_load_pkg;

    localparam int INST_W        = 128;

    localparam int GROUP_LSB     = 0;
    localparam int GROUP_W       = 6;
    localparam int BUF_START_LSB = 32;
    localparam int BUF_LEN_LSB   = 48;
    localparam int BUF_ROWS_W    = 11;
    localparam int DRAM_ADDR_LSB = 64;
    localparam int DRAM_LEN_LSB  = 80;

    localparam logic [GROUP_W-1:0] GRP_BUF0  = 6'h01;
    localparam logic [GROUP_W-1:0] GRP_BUF1A = 6'h02;
    localparam logic [GROUP_W-1:0] GRP_BUF1B = 6'h04;
    localparam logic [GROUP_W-1:0] GRP_BUF2A = 6'h08;
    localparam logic [GROUP_W-1:0] GRP_BUF2B = 6'h10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } dispatch_state_t;

    // A load is only safe to issue when it names one of the known buffer
    // groups and moves at least one row; a zero row count makes the load
    // stage's row counter wrap to 2047 and it never signals done.
    function automatic logic is_legal_load_inst(
        input logic [GROUP_W-1:0]    grp,
        input logic [BUF_ROWS_W-1:0] rows
    );
        logic grp_ok;
        grp_ok = (grp == GRP_BUF0)  || (grp == GRP_BUF1A) || (grp == GRP_BUF1B) ||
                 (grp == GRP_BUF2A) || (grp == GRP_BUF2B);
        return grp_ok && (rows != '0);
    endfunction

endpackage

// File: rtl/load_inst_fifo.sv
// load_inst_fifo
// Synchronous show-ahead FIFO: the head entry is visible on head_data
// whenever empty is low, and pop simply retires it.
// Ports:
//   kernel_clk, kernel_rst  clock, synchronous active-high reset (flushes)
//   push, push_data         write request / data (ignored while full)
//   pop                     retire head entry (ignored while empty)
//   head_data               current head entry
//   full, empty             occupancy flags
module load_inst_fifo #(
    parameter int WIDTH = 192,
    parameter int DEPTH = 16
) (
    input  logic             kernel_clk,
    input  logic             kernel_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Full blocks a push even when a pop happens on the same cycle, so the
    // upstream ready never depends on the dispatcher's pop decision.
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge kernel_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks
    // occupancy so a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge kernel_clk) begin
        if (kernel_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/load_inst_dispatch.sv
// load_inst_dispatch
// Queues load instructions from the fetcher, drops ones that would hang the
// load stage, issues the rest one at a time over ap_start/ap_done, and
// reports each completion with its buffer group.
// Ports:
//   kernel_clk, kernel_rst                    clock, synchronous active-high reset
//   inst_valid, inst_ready, inst_data         instruction intake (ready = !full)
//   addr_offset                               DRAM base captured with each instruction
//   load_ap_start, load_ap_done               load-stage handshake
//   load_ctrl_instruction/addr_offset         values presented to the load stage
//   done_valid, done_group                    completion report
//   err_pulse                                 an instruction was dropped
//   busy                                      queue non-empty or a load in progress
//   done_count, drop_count                    wrapping completion / drop counters
module load_inst_dispatch
    import gnn_load_pkg::*;
#(
    parameter int LOAD_INST_BIT_WIDTH = 128,
    parameter int C_M_AXI_ADDR_WIDTH  = 64,
    parameter int FIFO_DEPTH          = 16,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                           kernel_clk,
    input  logic                           kernel_rst,
    input  logic                           inst_valid,
    output logic                           inst_ready,
    input  logic [LOAD_INST_BIT_WIDTH-1:0] inst_data,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]  addr_offset,
    output logic                           load_ap_start,
    input  logic                           load_ap_done,
    output logic [LOAD_INST_BIT_WIDTH-1:0] load_ctrl_instruction,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]  load_ctrl_addr_offset,
    output logic                           done_valid,
    output logic [GROUP_W-1:0]             done_group,
    output logic                           err_pulse,
    output logic                           busy,
    output logic [CNT_WIDTH-1:0]           done_count,
    output logic [CNT_WIDTH-1:0]           drop_count
);

    localparam int ENTRY_W = C_M_AXI_ADDR_WIDTH + LOAD_INST_BIT_WIDTH;

    logic                           fifo_full;
    logic                           fifo_empty;
    logic                           fifo_pop;
    logic [ENTRY_W-1:0]             fifo_head;
    logic [LOAD_INST_BIT_WIDTH-1:0] head_inst;
    logic [C_M_AXI_ADDR_WIDTH-1:0]  head_addr;
    logic                           head_legal;
    dispatch_state_t                state;

    load_inst_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .kernel_clk (kernel_clk),
        .kernel_rst (kernel_rst),
        .push       (inst_valid),
        .push_data  ({addr_offset, inst_data}),
        .pop        (fifo_pop),
        .head_data  (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign head_inst  = fifo_head[LOAD_INST_BIT_WIDTH-1:0];
    assign head_addr  = fifo_head[ENTRY_W-1:LOAD_INST_BIT_WIDTH];
    assign head_legal = is_legal_load_inst(head_inst[GROUP_LSB +: GROUP_W],
                                           head_inst[BUF_LEN_LSB +: BUF_ROWS_W]);

    // Every head seen in IDLE is consumed: legal ones are issued, illegal
    // ones are discarded, so one bad instruction cannot block the queue.
    assign fifo_pop   = (state == IDLE) && !fifo_empty;
    assign inst_ready = !fifo_full;
    assign busy       = !fifo_empty || (state != IDLE);

    // Dispatch FSM with registered handshake/report outputs. The control
    // registers load only on a legal pop, so they stay stable for the whole
    // ISSUE/WAIT window. load_ap_done is only honoured in WAIT, which masks
    // the done level the load stage may show right after reset.
    always_ff @(posedge kernel_clk) begin
        if (kernel_rst) begin
            state                 <= IDLE;
            load_ap_start         <= 1'b0;
            load_ctrl_instruction <= '0;
            load_ctrl_addr_offset <= '0;
            done_valid            <= 1'b0;
            done_group            <= '0;
            err_pulse             <= 1'b0;
            done_count            <= '0;
            drop_count            <= '0;
        end else begin
            load_ap_start <= 1'b0;
            done_valid    <= 1'b0;
            err_pulse     <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (head_legal) begin
                            load_ctrl_instruction <= head_inst;
                            load_ctrl_addr_offset <= head_addr;
                            load_ap_start         <= 1'b1;
                            state                 <= ISSUE;
                        end else begin
                            err_pulse  <= 1'b1;
                            drop_count <= drop_count + CNT_WIDTH'(1);
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (load_ap_done) begin
                        done_valid <= 1'b1;
                        done_group <= load_ctrl_instruction[GROUP_LSB +: GROUP_W];
                        done_count <= done_count + CNT_WIDTH'(1);
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_inst_dispatch.sv
// tb_load_inst_dispatch
// Self-checking bench for load_inst_dispatch: a table of hand-derived
// vectors, several directed multi-cycle sequences, and a randomized run, all
// checked every cycle against a transaction-level reference model.
module tb_load_inst_dispatch;

    logic         kernel_clk = 1'b0;
    logic         kernel_rst;
    logic         inst_valid;
    logic         inst_ready;
    logic [127:0] inst_data;
    logic [63:0]  addr_offset;
    logic         load_ap_start;
    logic         load_ap_done;
    logic [127:0] load_ctrl_instruction;
    logic [63:0]  load_ctrl_addr_offset;
    logic         done_valid;
    logic [5:0]   done_group;
    logic         err_pulse;
    logic         busy;
    logic [15:0]  done_count;
    logic [15:0]  drop_count;

    load_inst_dispatch dut (
        .kernel_clk            (kernel_clk),
        .kernel_rst            (kernel_rst),
        .inst_valid            (inst_valid),
        .inst_ready            (inst_ready),
        .inst_data             (inst_data),
        .addr_offset           (addr_offset),
        .load_ap_start         (load_ap_start),
        .load_ap_done          (load_ap_done),
        .load_ctrl_instruction (load_ctrl_instruction),
        .load_ctrl_addr_offset (load_ctrl_addr_offset),
        .done_valid            (done_valid),
        .done_group            (done_group),
        .err_pulse             (err_pulse),
        .busy                  (busy),
        .done_count            (done_count),
        .drop_count            (drop_count)
    );

    // Free-running 10-time-unit clock.
    always #5 kernel_clk = ~kernel_clk;

    typedef struct {
        bit          valid;
        logic [5:0]  grp;
        logic [15:0] len;
        bit          done;
        bit          e_ready;
        bit          e_start;
        bit          e_err;
        bit          e_done_v;
        logic [5:0]  e_group;
        logic [15:0] e_drop;
        logic [15:0] e_done;
        bit          e_busy;
    } vec_t;

    int n_compared = 0;
    int n_failed   = 0;
    int cyc        = 0;

    // Reference model: a plain queue of entries plus "is a load outstanding".
    logic [191:0] mq[$];
    bit           m_valid = 0;
    bit           m_in_flight;
    int           m_start_cyc;
    logic [127:0] m_ctrl_inst;
    logic [63:0]  m_ctrl_addr;
    bit           e_start, e_err, e_done_v;
    logic [5:0]   e_group;
    logic [15:0]  e_done_cnt, e_drop_cnt;

    // Load-stage stub and observations.
    bit stub_on = 0, stub_random = 0, stray_on = 0;
    int stub_delay = 3;
    int stub_done_at = -1;
    int start_cycs[$];
    logic [5:0] done_groups[$];
    bit obs_ready, obs_busy, obs_done_valid;
    logic [15:0] obs_done_cnt, obs_drop_cnt;

    bit   row_active = 0;
    vec_t cur_row;

    logic [5:0] legal_g[5] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10};

    // A group is legal when it is a single set bit no higher than 0x10.
    function automatic bit model_legal(input logic [127:0] inst);
        logic [5:0] g;
        bit one_hot;
        g = inst[5:0];
        one_hot = (g != 6'h00) && ((g & (g - 6'h01)) == 6'h00) && (g <= 6'h10);
        return one_hot && (inst[58:48] != 11'd0);
    endfunction

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_in_flight  = 0;
        m_start_cyc  = 0;
        m_ctrl_inst  = '0;
        m_ctrl_addr  = '0;
        e_start      = 0;
        e_err        = 0;
        e_done_v     = 0;
        e_group      = '0;
        e_done_cnt   = '0;
        e_drop_cnt   = '0;
        stub_done_at = -1;
    endtask

    task automatic set_inst(input logic [5:0] g, input logic [15:0] len);
        inst_data          = {$urandom, $urandom, $urandom, $urandom};
        inst_data[5:0]     = g;
        inst_data[63:48]   = len;
        addr_offset        = {$urandom, $urandom};
    endtask

    task automatic applyStimulus(input vec_t v);
        inst_valid   = v.valid;
        set_inst(v.grp, v.len);
        load_ap_done = v.done;
    endtask

    task automatic checkOutput(input vec_t v);
        check("tbl_ready", inst_ready, v.e_ready);
        check("tbl_start", load_ap_start, v.e_start);
        check("tbl_err", err_pulse, v.e_err);
        check("tbl_done_valid", done_valid, v.e_done_v);
        if (v.e_done_v) check("tbl_done_group", done_group, v.e_group);
        if (v.e_start) check("tbl_start_group", load_ctrl_instruction[5:0], 6'h10);
        check("tbl_drop_count", drop_count, v.e_drop);
        check("tbl_done_count", done_count, v.e_done);
        check("tbl_busy", busy, v.e_busy);
    endtask

    task automatic compare_model();
        check("ready", inst_ready, mq.size() < 16);
        check("ap_start", load_ap_start, e_start);
        check("err_pulse", err_pulse, e_err);
        check("done_valid", done_valid, e_done_v);
        if (e_done_v) check("done_group", done_group, e_group);
        check("done_count", done_count, e_done_cnt);
        check("drop_count", drop_count, e_drop_cnt);
        check("busy", busy, (mq.size() != 0) || m_in_flight);
        check("ctrl_inst", load_ctrl_instruction, m_ctrl_inst);
        check("ctrl_addr", load_ctrl_addr_offset, m_ctrl_addr);
    endtask

    // One clock cycle: inputs are already driven; sample at the falling edge,
    // advance the model with this cycle's inputs, then cross the rising edge.
    task automatic step_cycle();
        bit           ready_now;
        logic [191:0] h;
        bit           n_start, n_err, n_done;
        if (stub_on) begin
            load_ap_done = (cyc == stub_done_at) || (stray_on && ($urandom_range(0, 15) == 0));
        end
        @(negedge kernel_clk);
        if (m_valid) compare_model();
        if (row_active) checkOutput(cur_row);
        obs_ready      = inst_ready;
        obs_busy       = busy;
        obs_done_valid = done_valid;
        obs_done_cnt   = done_count;
        obs_drop_cnt   = drop_count;
        if (load_ap_start) start_cycs.push_back(cyc);
        if (done_valid) done_groups.push_back(done_group);

        n_start   = 0;
        n_err     = 0;
        n_done    = 0;
        ready_now = mq.size() < 16;
        if (kernel_rst) begin
            model_reset();
            m_valid = 1;
        end else begin
            if (!m_in_flight && mq.size() != 0) begin
                h = mq.pop_front();
                if (model_legal(h[127:0])) begin
                    m_ctrl_inst = h[127:0];
                    m_ctrl_addr = h[191:128];
                    m_in_flight = 1;
                    m_start_cyc = cyc + 1;
                    n_start     = 1;
                    if (stub_on)
                        stub_done_at = cyc + 1 + (stub_random ? int'($urandom_range(1, 6)) : stub_delay);
                end else begin
                    n_err      = 1;
                    e_drop_cnt = e_drop_cnt + 16'd1;
                end
            end else if (m_in_flight && (cyc > m_start_cyc) && load_ap_done) begin
                n_done      = 1;
                e_group     = m_ctrl_inst[5:0];
                e_done_cnt  = e_done_cnt + 16'd1;
                m_in_flight = 0;
            end
            if (inst_valid && ready_now) mq.push_back({addr_offset, inst_data});
            e_start  = n_start;
            e_err    = n_err;
            e_done_v = n_done;
        end
        @(posedge kernel_clk);
        #1;
        cyc++;
    endtask

    task automatic reset_dut();
        kernel_rst   = 1;
        inst_valid   = 0;
        load_ap_done = 0;
        stub_on      = 0;
        stub_random  = 0;
        stray_on     = 0;
        repeat (2) step_cycle();
        kernel_rst = 0;
        start_cycs.delete();
        done_groups.delete();
    endtask

    // Top-level test sequence.
    initial begin
        vec_t tbl[9];
        int   p;
        int   d;

        // Illegal-drop sequence, expected values derived by hand.
        tbl[0] = '{1, 6'h03, 16'd5, 0,  1, 0, 0, 0, 6'h00, 16'd0, 16'd0, 0};
        tbl[1] = '{1, 6'h01, 16'd0, 0,  1, 0, 0, 0, 6'h00, 16'd0, 16'd0, 1};
        tbl[2] = '{1, 6'h10, 16'd4, 0,  1, 0, 1, 0, 6'h00, 16'd1, 16'd0, 1};
        tbl[3] = '{0, 6'h00, 16'd0, 0,  1, 0, 1, 0, 6'h00, 16'd2, 16'd0, 1};
        tbl[4] = '{0, 6'h00, 16'd0, 0,  1, 1, 0, 0, 6'h00, 16'd2, 16'd0, 1};
        tbl[5] = '{0, 6'h00, 16'd0, 0,  1, 0, 0, 0, 6'h00, 16'd2, 16'd0, 1};
        tbl[6] = '{0, 6'h00, 16'd0, 1,  1, 0, 0, 0, 6'h00, 16'd2, 16'd0, 1};
        tbl[7] = '{0, 6'h00, 16'd0, 0,  1, 0, 0, 1, 6'h10, 16'd2, 16'd1, 0};
        tbl[8] = '{0, 6'h00, 16'd0, 0,  1, 0, 0, 0, 6'h00, 16'd2, 16'd1, 0};

        inst_data   = '0;
        addr_offset = '0;
        reset_dut();

        $display("[TB] table: illegal drops then one legal load");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i]);
            cur_row    = tbl[i];
            row_active = 1;
            step_cycle();
        end
        row_active   = 0;
        load_ap_done = 0;
        inst_valid   = 0;
        check("drop_start_count", start_cycs.size(), 1);

        $display("[TB] single legal instruction");
        reset_dut();
        stub_on    = 1;
        stub_delay = 10;
        p          = cyc;
        inst_valid = 1;
        set_inst(6'h04, 16'd8);
        step_cycle();
        inst_valid = 0;
        repeat (16) step_cycle();
        check("single_start_count", start_cycs.size(), 1);
        check("single_latency", (start_cycs.size() != 0) ? start_cycs[0] - p : -1, 2);
        check("single_done_count", done_groups.size(), 1);
        check("single_done_group", (done_groups.size() != 0) ? done_groups[0] : 6'h3f, 6'h04);
        check("single_done_counter", obs_done_cnt, 1);

        $display("[TB] full queue");
        reset_dut();
        for (int k = 0; k < 17; k++) begin
            inst_valid = 1;
            set_inst(legal_g[k % 5], 16'(k + 1));
            step_cycle();
        end
        inst_valid = 0;
        step_cycle();
        check("full_not_ready", obs_ready, 0);
        repeat (2) step_cycle();
        load_ap_done = 1;
        step_cycle();
        load_ap_done = 0;
        step_cycle();
        step_cycle();
        check("ready_after_done", obs_ready, 1);

        $display("[TB] stray done");
        reset_dut();
        load_ap_done = 1;
        repeat (2) step_cycle();
        inst_valid = 1;
        set_inst(6'h08, 16'd3);
        step_cycle();
        inst_valid = 0;
        repeat (2) step_cycle();
        load_ap_done = 0;
        step_cycle();
        check("stray_no_done", done_groups.size(), 0);
        check("stray_done_counter", obs_done_cnt, 0);
        load_ap_done = 1;
        step_cycle();
        load_ap_done = 0;
        step_cycle();
        check("stray_real_done", obs_done_valid, 1);
        check("stray_real_counter", obs_done_cnt, 1);

        $display("[TB] back-to-back");
        reset_dut();
        stub_on    = 1;
        stub_delay = 3;
        for (int k = 0; k < 4; k++) begin
            inst_valid = 1;
            set_inst(legal_g[k], 16'(4 + k));
            step_cycle();
        end
        inst_valid = 0;
        repeat (30) step_cycle();
        check("b2b_start_count", start_cycs.size(), 4);
        for (int i = 1; i < 4; i++) begin
            d = (start_cycs.size() > i) ? start_cycs[i] - start_cycs[i-1] : -1;
            check("b2b_spacing", d, 5);
        end
        check("b2b_done_count", done_groups.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("b2b_group_order", (done_groups.size() > i) ? done_groups[i] : 6'h3f, legal_g[i]);
        end

        $display("[TB] reset while waiting");
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            inst_valid = 1;
            set_inst(legal_g[4 - k], 16'd2);
            step_cycle();
        end
        inst_valid = 0;
        kernel_rst = 1;
        step_cycle();
        kernel_rst = 0;
        start_cycs.delete();
        done_groups.delete();
        step_cycle();
        check("rst_busy", obs_busy, 0);
        check("rst_ready", obs_ready, 1);
        check("rst_done_counter", obs_done_cnt, 0);
        check("rst_drop_counter", obs_drop_cnt, 0);
        repeat (20) step_cycle();
        check("rst_no_start", start_cycs.size(), 0);
        check("rst_no_done", done_groups.size(), 0);

        $display("[TB] randomized traffic");
        reset_dut();
        stub_on     = 1;
        stub_random = 1;
        stray_on    = 1;
        for (int i = 0; i < 2000; i++) begin
            logic [5:0]  g;
            logic [15:0] len;
            int          r;
            r = $urandom_range(0, 7);
            if (r == 0)      g = 6'h03;
            else if (r == 1) g = 6'(($urandom_range(0, 1) == 0) ? 0 : 32);
            else             g = legal_g[$urandom_range(0, 4)];
            len = 16'($urandom);
            if ($urandom_range(0, 9) == 0) len[10:0] = 11'd0;
            inst_valid = ($urandom_range(0, 2) != 0);
            set_inst(g, len);
            kernel_rst = ($urandom_range(0, 399) == 0);
            step_cycle();
        end
        kernel_rst = 0;
        inst_valid = 0;
        step_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
